// File: rtl/cordicmul.sv
// Iterative linear-rotation CORDIC multiplier: out = x * z in signed Q(INT_SIZE).(FLOAT_SIZE).
// Optional output saturation and overflow flag when CORDICMUL_SAT_EN is defined.
module cordicmul #(
  parameter int INT_SIZE   = 8,
  parameter int FLOAT_SIZE = 24,
  parameter int ITER       = 24
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           EN,
  input  logic [INT_SIZE+FLOAT_SIZE-1:0] x,
  input  logic [INT_SIZE+FLOAT_SIZE-1:0] z,
  output logic [INT_SIZE+FLOAT_SIZE-1:0] out,
  output logic                           BUSY,
  output logic                           DONE,
  output logic                           OVF
);

  localparam int W  = INT_SIZE + FLOAT_SIZE;
  localparam int YW = W + 2;
  localparam int IW = $clog2(ITER + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    xr_q, xr_d;
  logic [W-1:0]    zr_q, zr_d;
  logic [YW-1:0]   y_q, y_d;
  logic [IW-1:0]   i_q, i_d;
  logic [W-1:0]    out_q, out_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;

  logic signed [YW-1:0] xs_s;
  logic [7:0]           sh_s;
  logic [W-1:0]         step_s;

  // Accumulator fits the output format when both guard bits match the output sign bit.
  function automatic logic fits_fn(input logic [YW-1:0] v);
    logic fits_v;
    if ((v[YW-1:W-1] == 3'b000) || (v[YW-1:W-1] == 3'b111)) begin
      fits_v = 1'b1;
    end else begin
      fits_v = 1'b0;
    end
    return fits_v;
  endfunction

  function automatic logic [W-1:0] sat_fn(input logic [YW-1:0] v);
    logic [W-1:0] r_v;
    if (fits_fn(v)) begin
      r_v = v[W-1:0];
    end else if (v[YW-1]) begin
      r_v = {1'b1, {(W-1){1'b0}}};
    end else begin
      r_v = {1'b0, {(W-1){1'b1}}};
    end
    return r_v;
  endfunction

  // Next-state, datapath and output computation.
  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    zr_d    = zr_q;
    y_d     = y_q;
    i_d     = i_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    xs_s    = $signed({{2{xr_q[W-1]}}, xr_q}) >>> i_q;
    sh_s    = 8'(FLOAT_SIZE) - 8'(i_q);
    step_s  = {{(W-1){1'b0}}, 1'b1} << sh_s;
    case (state_q)
      S_IDLE: begin
        if (EN) begin
          xr_d    = x;
          zr_d    = z;
          y_d     = {YW{1'b0}};
          i_d     = {IW{1'b0}};
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // Non-negative residual (including zero) rotates in the +1 direction.
        if (!zr_q[W-1]) begin
          y_d  = y_q + xs_s;
          zr_d = zr_q - step_s;
        end else begin
          y_d  = y_q - xs_s;
          zr_d = zr_q + step_s;
        end
        i_d = i_q + {{(IW-1){1'b0}}, 1'b1};
        if (i_q == IW'(ITER - 1)) begin
          busy_d  = 1'b0;
          state_d = S_FIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIN: begin
`ifdef CORDICMUL_SAT_EN
        out_d = sat_fn(y_q);
        ovf_d = ~fits_fn(y_q);
`else
        out_d = y_q[W-1:0];
        ovf_d = 1'b0;
`endif
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      xr_q    <= {W{1'b0}};
      zr_q    <= {W{1'b0}};
      y_q     <= {YW{1'b0}};
      i_q     <= {IW{1'b0}};
      out_q   <= {W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      zr_q    <= zr_d;
      y_q     <= y_d;
      i_q     <= i_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out  = out_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign OVF  = ovf_q;

endmodule

// File: tb/tb_cordicmul.sv
// Directed self-checking bench for cordicmul; expected values are hand-derived CORDIC results.
module tb_cordicmul;

  logic        CLK;
  logic        RST;
  logic        EN;
  logic [31:0] x;
  logic [31:0] z;
  logic [31:0] out;
  logic        BUSY;
  logic        DONE;
  logic        OVF;

  int n_checks;
  int n_errors;
  int done_at;
  int busy_cnt;
  int done_cnt;
  int idle_busy;

  cordicmul dut (
    .CLK (CLK),
    .RST (RST),
    .EN  (EN),
    .x   (x),
    .z   (z),
    .out (out),
    .BUSY(BUSY),
    .DONE(DONE),
    .OVF (OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one operation; optionally re-pulse EN (with other operands) or assert RST mid-run.
  task automatic run_op(input logic [31:0] xa, input logic [31:0] za,
                        input int en_again_at, input int rst_at,
                        output int d_at, output int b_cnt, output int d_cnt);
    d_at  = -1;
    b_cnt = 0;
    d_cnt = 0;
    @(negedge CLK);
    x  = xa;
    z  = za;
    EN = 1'b1;
    @(negedge CLK);
    EN = 1'b0;
    if (BUSY) b_cnt++;
    for (int c = 1; c <= 32; c++) begin
      @(negedge CLK);
      EN = 1'b0;
      if (BUSY) b_cnt++;
      if (DONE) begin
        d_cnt++;
        if (d_at < 0) d_at = c;
      end
      if (c == en_again_at) begin
        x  = 32'h7F000000;
        z  = 32'h00100000;
        EN = 1'b1;
      end
      if (c == rst_at) RST = 1'b1;
      if (c == rst_at + 2) RST = 1'b0;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    idle_busy = 0;
    RST = 1'b1;
    EN  = 1'b1;
    x   = 32'h01000000;
    z   = 32'h01000000;

    repeat (3) @(negedge CLK);
    chk("rst_out",  out,         32'h00000000);
    chk("rst_busy", 32'(BUSY),   32'd0);
    chk("rst_done", 32'(DONE),   32'd0);
    chk("rst_ovf",  32'(OVF),    32'd0);

    EN = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      if (BUSY || DONE) idle_busy++;
    end
    chk("idle_quiet", 32'(idle_busy), 32'd0);

    // 1.0 * 1.0
    run_op(32'h01000000, 32'h01000000, -1, -1, done_at, busy_cnt, done_cnt);
    chk("unit_latency", 32'(done_at),  32'd25);
    chk("unit_busy",    32'(busy_cnt), 32'd24);
    chk("unit_ndone",   32'(done_cnt), 32'd1);
    chk("unit_out",     out,           32'h01000002);
    chk("unit_ovf",     32'(OVF),      32'd0);

    // 2.0 * 0.5
    run_op(32'h02000000, 32'h00800000, -1, -1, done_at, busy_cnt, done_cnt);
    chk("half_out",   out,           32'h01000004);
    chk("half_ndone", 32'(done_cnt), 32'd1);

    // -1.5 * 0.25 -> -0.375 - 3 LSB
    run_op(32'hFE800000, 32'h00400000, -1, -1, done_at, busy_cnt, done_cnt);
    chk("signed_out", out, 32'hFF9FFFFD);

    // EN re-pulsed at cycle 10 with different operands is ignored
    run_op(32'h02000000, 32'h00800000, 10, -1, done_at, busy_cnt, done_cnt);
    chk("busy_en_ndone", 32'(done_cnt), 32'd1);
    chk("busy_en_out",   out,           32'h01000004);
    chk("busy_en_idle",  32'(BUSY),     32'd0);

    // 100.0 * 1.5 overflows Q8.24
    run_op(32'h64000000, 32'h01800000, -1, -1, done_at, busy_cnt, done_cnt);
    chk("big_ndone", 32'(done_cnt), 32'd1);
`ifdef CORDICMUL_SAT_EN
    chk("sat_out", out,        32'h7FFFFFFF);
    chk("sat_ovf", 32'(OVF),   32'd1);
`else
    chk("wrap_out", out,       32'h960000C8);
    chk("wrap_ovf", 32'(OVF),  32'd0);
`endif

    run_op(32'h01000000, 32'h01000000, -1, -1, done_at, busy_cnt, done_cnt);
    chk("post_ovf", 32'(OVF), 32'd0);
    chk("post_out", out,      32'h01000002);

    // Reset at cycle 12 aborts the run
    run_op(32'h02000000, 32'h00800000, -1, 12, done_at, busy_cnt, done_cnt);
    chk("abort_ndone", 32'(done_cnt), 32'd0);
    chk("abort_out",   out,           32'h00000000);
    chk("abort_busy",  32'(BUSY),     32'd0);
    chk("abort_ovf",   32'(OVF),      32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cordicmul.md
Name: cordicmul

Overview:
- Iterative linear-rotation CORDIC multiplier: out = x * z in signed Q(INT_SIZE).(FLOAT_SIZE) fixed point.
- It is the inverse-direction companion of the team's linear-vectoring CORDIC divider. It shares the same number format, the EN start-pulse convention and the out-holds-result convention.
- Sits beside the divider in the CORDIC arithmetic set. Used where a multiply is needed without a hard multiplier.

Parameters:
- INT_SIZE, 8, integer bits including sign.
- FLOAT_SIZE, 24, fractional bits.
- ITER, 24, CORDIC iterations; shift index i runs 0..ITER-1; must be <= FLOAT_SIZE.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- EN  in  1  start pulse; sampled only in IDLE.
- x  in  INT_SIZE+FLOAT_SIZE  signed multiplicand, Q8.24.
- z  in  INT_SIZE+FLOAT_SIZE  signed multiplier, Q8.24; valid domain -2.0 < z < 2.0.
- out  out  INT_SIZE+FLOAT_SIZE  signed product, Q8.24; holds the last result.
- BUSY  out  1  high while iterating.
- DONE  out  1  one-cycle pulse when out is updated.
- OVF  out  1  overflow flag for the last result (always 0 without the optional feature).

Behaviour:
- Reset: RST is asynchronous and active-high. While RST is high, FSM = IDLE, out = 0, BUSY = 0, DONE = 0, OVF = 0, and internal registers = 0. RST asserted mid-operation aborts the operation and discards it; no DONE follows.
- States: IDLE, RUN, FIN.
- IDLE: on a rising edge with EN=1:
  - Capture x into xr.
  - Load accumulator y=0 and residual zr=z.
  - Set i=0, BUSY=1, go to RUN.
- RUN: one iteration per cycle.
  - d = +1 if zr >= 0, else d = -1. Tie-break: zr==0 takes d=+1.
  - y <= y + d*(xr >>> i), arithmetic shift.
  - zr <= zr - d*(1 << (FLOAT_SIZE-i)).
  - i <= i+1.
  - After the iteration with i = ITER-1, go to FIN.
- FIN: in a single cycle:
  - out <= y truncated to INT_SIZE+FLOAT_SIZE.
  - DONE=1 for exactly this cycle.
  - BUSY=0.
  - Return to IDLE.
- Latency: EN sampled at edge k, out and DONE are valid after edge k+ITER+1. A new EN is accepted at edge k+ITER+2 or later.
- EN=1 while BUSY is ignored; it is not queued. x and z may change freely after the EN edge.
- Width rules: y is INT_SIZE+FLOAT_SIZE+2 bits (2 guard bits) so intermediate sums cannot wrap for any x with |z|<2. zr is the same width as z.
- Accuracy: |out - x*z| <= |x|*2^-(ITER-1) + ITER LSB.
- Results for |z| >= 2 are unspecified but must complete with a DONE pulse. The FSM must never hang.
- out is not modified except in FIN and reset.

Optional Feature:
- Macro CORDICMUL_SAT_EN.
- Defined: in FIN, if y exceeds the Q8.24 range:
  - Positive overflow: out = 0x7FFFFFFF (max positive), OVF=1.
  - Negative overflow: out = 0x80000000 (min negative), OVF=1.
  - Otherwise OVF=0.
  - OVF is updated only in FIN and cleared by reset.
- Undefined: out is the low INT_SIZE+FLOAT_SIZE bits of y (wrap) and OVF is tied to 0.

Test Plan:
- Reset behaviour: hold RST with EN=1 -> out=0, BUSY=0, DONE=0, OVF=0. After release, no activity until an EN pulse.
- Unit product: x=0x01000000 (1.0), z=0x01000000 (1.0), one-cycle EN -> DONE 25 cycles after the EN edge; out=0x01000002; BUSY high for exactly 24 cycles.
- Half scaling: x=0x02000000 (2.0), z=0x00800000 (0.5) -> out=0x01000004.
- Signed input: x=0xFE800000 (-1.5), z=0x00400000 (0.25) -> out within ±4 LSB of 0xFFA00000 (-0.375).
- EN during BUSY, then mid-run reset:
  - EN pulsed again at cycle 10 of a run -> exactly one DONE, result from the first operands.
  - RST at cycle 12 of a new run -> no DONE; out=0.
- Saturation (with CORDICMUL_SAT_EN): x=0x64000000 (100.0), z=0x01800000 (1.5) -> out=0x7FFFFFFF, OVF=1. Following 1.0*1.0 run -> OVF=0. Without the macro -> OVF=0 and out = wrapped low 32 bits.
